// File: rtl/ser_pkg.sv
// Shared definitions for the serial-arithmetic blocks: default frame width
// and the deserializer state encoding.
package ser_pkg;

  localparam int SER_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } deser_state_t;

endpackage

// File: rtl/sum_deser_if.sv
// Serial-sum in / parallel-result out bundle for sum_deser.
// Optional macro SUM_DESER_CARRY_EN adds carry_in / result_carry.
interface sum_deser_if #(
  parameter int WIDTH = ser_pkg::SER_WIDTH
);

  logic             mode;
  logic             sum_in;
  logic             result_ack;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             overrun;
`ifdef SUM_DESER_CARRY_EN
  logic             carry_in;
  logic             result_carry;
`endif

`ifdef SUM_DESER_CARRY_EN
  modport master (
    output mode, sum_in, result_ack, carry_in,
    input  result, result_valid, overrun, result_carry
  );
  modport slave (
    input  mode, sum_in, result_ack, carry_in,
    output result, result_valid, overrun, result_carry
  );
`else
  modport master (
    output mode, sum_in, result_ack,
    input  result, result_valid, overrun
  );
  modport slave (
    input  mode, sum_in, result_ack,
    output result, result_valid, overrun
  );
`endif

endinterface

// File: rtl/ser_bit_counter.sv
// Bit position counter 0..WIDTH-1 with synchronous clear and wrap on terminal
// count. Shared by the serial adder and the sum deserializer.
module ser_bit_counter #(
  parameter  int WIDTH = ser_pkg::SER_WIDTH,
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          terminal
);

  logic [CW-1:0] count_reg;

  assign count    = count_reg;
  assign terminal = (count_reg == CW'(WIDTH - 1));

  // Count enabled cycles; clear wins over enable, terminal count wraps to 0.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= terminal ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/sum_deser.sv
// sum_deser: collects an LSB-first serial sum into a parallel result with a
// valid/ack handshake and a sticky overrun flag.
// Optional macro SUM_DESER_CARRY_EN captures the upstream final carry too.
module sum_deser
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input logic        clk,
  input logic        reset,
  sum_deser_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  deser_state_t     state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] result_reg;
  logic             valid_reg;
  logic             overrun_reg;
  logic [CW-1:0]    bit_count;
  logic             bit_last;
  logic             sample;
  logic             complete;
  logic [WIDTH-1:0] shift_next;

  // A sample happens on any shift cycle unless a finished frame is being held.
  assign sample     = !bus.mode && (state_reg != HOLD);
  assign complete   = sample && bit_last;
  assign shift_next = {bus.sum_in, shift_reg[WIDTH-1:1]};

  // mode=1 restarts bit numbering regardless of state.
  ser_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (bus.mode),
    .enable   (sample),
    .count    (bit_count),
    .terminal (bit_last)
  );

  // Frame FSM plus result/valid/overrun registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      result_reg  <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (bus.mode) begin
        // Partial frames are dropped silently; outputs keep their values.
        state_reg <= IDLE;
      end else if (sample) begin
        shift_reg <= shift_next;
        state_reg <= bit_last ? HOLD : SHIFT;
      end

      if (complete) begin
        result_reg <= shift_next;
        valid_reg  <= 1'b1;
        // An ack on the completion edge consumes the old frame, so no overrun.
        if (valid_reg && !bus.result_ack) begin
          overrun_reg <= 1'b1;
        end
      end else if (bus.result_ack) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign bus.result       = result_reg;
  assign bus.result_valid = valid_reg;
  assign bus.overrun      = overrun_reg;

`ifdef SUM_DESER_CARRY_EN
  logic carry_reg;

  // Final carry follows exactly the same load rule as result.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_reg <= 1'b0;
    end else if (complete) begin
      carry_reg <= bus.carry_in;
    end
  end

  assign bus.result_carry = carry_reg;
`endif

  // Diagnostic only: the count is consumed via the terminal flag.
  logic unused_count;
  assign unused_count = ^bit_count;

endmodule

// File: tb/tb_sum_deser.sv
// Testbench for sum_deser: frames are pushed to a scoreboard queue as they
// are driven and popped when the completed result appears.
module tb_sum_deser;
  import ser_pkg::*;

  logic clk = 1'b0;
  logic reset;

  logic [15:0] exp_q[$];
  logic [15:0] exp_v;
  int n_cmp = 0;
  int n_bad = 0;

  sum_deser_if #(.WIDTH(16)) bus ();

  sum_deser #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    bus.mode = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_bits(input logic [15:0] v, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.mode   = 1'b0;
      bus.sum_in = v[i];
      tick();
    end
  endtask

  // Full frame; result expectation goes to the scoreboard first.
  task automatic send_frame(input logic [15:0] v, input logic c, input logic ack_last);
    exp_q.push_back(v);
`ifdef SUM_DESER_CARRY_EN
    bus.carry_in = c;
`else
    if (c) begin end
`endif
    send_bits(v, 15);
    bus.result_ack = ack_last;
    send_bits({1'b0, v[15:1]} >> 14, 1);
    bus.result_ack = 1'b0;
  endtask

  task automatic do_ack();
    bus.result_ack = 1'b1;
    bus.mode = 1'b1;
    tick();
    bus.result_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if (bus.result !== 16'h0) begin n_bad++; $display("FAIL reset_result got %h want 0000", bus.result); end
    n_cmp++; if (bus.result_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus.result_valid); end
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
    $display("reset: result=%h valid=%b overrun=%b", bus.result, bus.result_valid, bus.overrun);
  endtask

  task automatic test_basic();
    idle_cycles(2);
    exp_q.push_back(16'h2345);
    send_bits(16'h2345, 15);
    n_cmp++; if (bus.result_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid got %b want 0", bus.result_valid); end
    send_bits(16'h0001 & (16'h2345 >> 15), 1);
    exp_v = exp_q.pop_front();
    n_cmp++; if (bus.result !== exp_v) begin n_bad++; $display("FAIL basic_result got %h want %h", bus.result, exp_v); end
    n_cmp++; if (bus.result_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", bus.result_valid); end
    $display("basic: result=%h valid=%b", bus.result, bus.result_valid);
    do_ack();
    n_cmp++; if (bus.result_valid !== 1'b0) begin n_bad++; $display("FAIL basic_ack got %b want 0", bus.result_valid); end
    n_cmp++; if (bus.result !== 16'h2345) begin n_bad++; $display("FAIL basic_keep got %h want 2345", bus.result); end
    // Ack with nothing valid is ignored.
    do_ack();
    n_cmp++; if (bus.result_valid !== 1'b0) begin n_bad++; $display("FAIL spurious_ack got %b want 0", bus.result_valid); end
  endtask

  task automatic test_hold();
    idle_cycles(1);
    send_frame(16'h2345, 1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    send_bits(16'hFFFF, 4);
    n_cmp++; if (bus.result !== exp_v) begin n_bad++; $display("FAIL hold_result got %h want %h", bus.result, exp_v); end
    n_cmp++; if (bus.result_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid got %b want 1", bus.result_valid); end
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL hold_overrun got %b want 0", bus.overrun); end
    n_cmp++; if (dut.state_reg !== HOLD) begin n_bad++; $display("FAIL hold_state got %0d want %0d", dut.state_reg, HOLD); end
    $display("hold: result=%h valid=%b state=%0d", bus.result, bus.result_valid, dut.state_reg);
    do_ack();
  endtask

  task automatic test_abort();
    idle_cycles(1);
    send_bits(16'h0055, 7);
    idle_cycles(1);
    n_cmp++; if (bus.result_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid got %b want 0", bus.result_valid); end
    send_frame(16'hFFFF, 1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (bus.result !== exp_v) begin n_bad++; $display("FAIL abort_result got %h want %h", bus.result, exp_v); end
    n_cmp++; if (bus.result_valid !== 1'b1) begin n_bad++; $display("FAIL abort_frame_valid got %b want 1", bus.result_valid); end
    $display("abort: result=%h valid=%b", bus.result, bus.result_valid);
    do_ack();
  endtask

  task automatic test_overrun();
    idle_cycles(1);
    send_frame(16'h0001, 1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (bus.result !== exp_v) begin n_bad++; $display("FAIL ovr_first got %h want %h", bus.result, exp_v); end
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_early got %b want 0", bus.overrun); end
    idle_cycles(1);
    send_frame(16'h8000, 1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (bus.result !== exp_v) begin n_bad++; $display("FAIL ovr_result got %h want %h", bus.result, exp_v); end
    n_cmp++; if (bus.result_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid got %b want 1", bus.result_valid); end
    n_cmp++; if (bus.overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag got %b want 1", bus.overrun); end
    $display("overrun: result=%h valid=%b overrun=%b", bus.result, bus.result_valid, bus.overrun);
    do_ack();
    n_cmp++; if (bus.overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got %b want 1", bus.overrun); end
  endtask

  task automatic test_back_to_back();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_reset_ovr got %b want 0", bus.overrun); end
    send_frame(16'h1234, 1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (bus.result !== exp_v) begin n_bad++; $display("FAIL b2b_first got %h want %h", bus.result, exp_v); end
    idle_cycles(1);
    send_frame(16'h5678, 1'b0, 1'b1);
    exp_v = exp_q.pop_front();
    n_cmp++; if (bus.result !== exp_v) begin n_bad++; $display("FAIL b2b_result got %h want %h", bus.result, exp_v); end
    n_cmp++; if (bus.result_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid got %b want 1", bus.result_valid); end
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun got %b want 0", bus.overrun); end
    $display("back_to_back: result=%h valid=%b overrun=%b", bus.result, bus.result_valid, bus.overrun);
    do_ack();
  endtask

  task automatic test_reset_mid();
    // Leave a valid result and overrun set, then reset mid-frame.
    idle_cycles(1);
    send_frame(16'h0F0F, 1'b1, 1'b0);
    exp_v = exp_q.pop_front();
    idle_cycles(1);
    send_frame(16'h00FF, 1'b1, 1'b0);
    exp_v = exp_q.pop_front();
    idle_cycles(1);
    send_bits(16'h01FF, 9);
    reset = 1'b1;
    bus.mode = 1'b0;
    bus.result_ack = 1'b1;
    tick();
    reset = 1'b0;
    bus.result_ack = 1'b0;
    n_cmp++; if (bus.result !== 16'h0) begin n_bad++; $display("FAIL rst_mid_result got %h want 0000", bus.result); end
    n_cmp++; if (bus.result_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid got %b want 0", bus.result_valid); end
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL rst_mid_overrun got %b want 0", bus.overrun); end
`ifdef SUM_DESER_CARRY_EN
    n_cmp++; if (bus.result_carry !== 1'b0) begin n_bad++; $display("FAIL rst_mid_carry got %b want 0", bus.result_carry); end
`endif
    send_frame(16'hA5A5, 1'b1, 1'b0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (bus.result !== exp_v) begin n_bad++; $display("FAIL rst_frame_result got %h want %h", bus.result, exp_v); end
    n_cmp++; if (bus.result_valid !== 1'b1) begin n_bad++; $display("FAIL rst_frame_valid got %b want 1", bus.result_valid); end
`ifdef SUM_DESER_CARRY_EN
    n_cmp++; if (bus.result_carry !== 1'b1) begin n_bad++; $display("FAIL rst_frame_carry got %b want 1", bus.result_carry); end
`endif
    $display("reset_mid: result=%h valid=%b", bus.result, bus.result_valid);
  endtask

  initial begin
    reset          = 1'b1;
    bus.mode       = 1'b1;
    bus.sum_in     = 1'b0;
    bus.result_ack = 1'b0;
`ifdef SUM_DESER_CARRY_EN
    bus.carry_in   = 1'b0;
`endif
    test_reset();
    test_basic();
    test_hold();
    test_abort();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
